fcla16_share_sched: RTL and testbench
=====================================

Name: fcla16_share_sched

Overview:
- Time-multiplexes one internal fcla16 16-bit carry-lookahead adder among NREQ requesters.
- Round-robin arbitration selects the requester. Operands are latched into a single in-flight slot.
- 32-bit adds are sequenced as two 16-bit passes, with the carry chained from the low pass into the high pass.
- Sits between the arithmetic requesters (MAC and address units) and the shared adder, replacing per-requester adders.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester-ID field; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  input  NREQ*32  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_wide  input  NREQ  1 = 32-bit add; 0 = 16-bit add (upper 16 operand bits ignored).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_sum  output  32  sum; bits [31:16] are zero for 16-bit ops.
- resp_cout  output  1  carry-out from bit 15 (narrow op) or bit 31 (wide op).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset state: state = IDLE, rr_ptr = 0, all operand/result registers = 0.
- Reset outputs: req_ready = 0, resp_valid = 0, resp_id = 0, resp_sum = 0, resp_cout = 0, busy = 0.
- Reset asserted mid-operation aborts the slot immediately; no response is issued for the aborted request.

State machine (IDLE, LO, HI, RESP):
- IDLE:
  - req_ready[g] = 1 combinationally for the round-robin winner g: the first valid index at or after rr_ptr, wrapping.
  - On the handshake, latch a, b, cin, wide and id = g; set rr_ptr = (g+1) mod NREQ; go to LO.
  - No valid requests: stay in IDLE and leave rr_ptr unchanged.
- LO:
  - Adder inputs are a[15:0], b[15:0], cin. Register sum_lo.
  - Register c16 = G | (P & cin), using the adder's G and P outputs.
  - wide = 1: go to HI. wide = 0: go to RESP.
- HI:
  - Adder inputs are a[31:16], b[31:16], c16. Register sum_hi.
  - Register c32 = G | (P & c16). Go to RESP.
- RESP:
  - resp_valid = 1. resp_sum = {sum_hi, sum_lo}, with sum_hi = 0 for narrow ops. resp_cout = wide ? c32 : c16.
  - All response outputs are registered and hold stable while resp_valid = 1 and resp_ready = 0.
  - On resp_ready = 1: go to IDLE.
  - No new grant is issued in the same cycle as the response handshake; the next grant is at the earliest one cycle later.
- Latency (handshake cycle = T):
  - Narrow: resp_valid rises at T+2.
  - Wide: resp_valid rises at T+3.
  - Back-to-back throughput is 1 op per 3 cycles (narrow) or 4 cycles (wide) when resp_ready is held at 1.
- Arithmetic: results are modulo 2^16 (narrow) or 2^32 (wide). Overflow is reported only via resp_cout; there are no exceptions.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid asserted and keep their operands stable until granted.
- Requester rules: requesters must not change operands while req_valid = 1 and req_ready = 0. req_valid dropping before grant is legal and simply withdraws the request.
- req_ready is 0 in every state except IDLE.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,... Maximum wait is NREQ-1 operations.
- Adder use: the shared fcla16 instance is used only in LO and HI. Its inputs are held at 0 in IDLE and RESP to limit toggling.

Test Plan:
- Narrow add: requester 1, a = 0x0000_FFFF, b = 0x0000_0001, cin = 0 -> resp_id = 1, resp_sum = 0x0000_0000, resp_cout = 1, resp_valid at T+2.
- Wide carry chain: requester 0, a = 0x0000_FFFF, b = 0x0000_0001, cin = 0 -> resp_sum = 0x0001_0000, resp_cout = 0, resp_valid at T+3.
- Wide overflow: a = 0xFFFF_FFFF, b = 0x0000_0000, cin = 1 -> resp_sum = 0x0000_0000, resp_cout = 1.
- Round-robin: all 4 requesters valid continuously with resp_ready = 1 -> grant order 0,1,2,3,0.
  - Then drop requester 1 after its first grant -> order continues 2,3,0,2.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP.
  - resp_sum, resp_id and resp_cout stay stable; req_ready stays 0 for all requesters.
  - After release, next grant occurs one cycle after the response handshake.
- Reset in HI: assert rst_n = 0 during the HI cycle of a wide op -> all outputs zero immediately; after release, no stale resp_valid and rr_ptr = 0.

Source files
------------

// File: rtl/fcla16_share_sched.sv
// Shared 16-bit carry-lookahead adder, time-multiplexed among NREQ requesters.
// Round-robin grant, one in-flight slot, 32-bit adds chained as two 16-bit passes.

module fcla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        g,
    output logic        p
);
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  pp_s;
    logic [3:0]  gc_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Per-nibble group generate and propagate
    always_comb begin
        gg_s = 4'h0;
        pp_s = 4'h0;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            pp_s[k] = &p_s[4*k +: 4];
        end
    end

    assign gc_s[0] = cin;
    assign gc_s[1] = gg_s[0] | (pp_s[0] & cin);
    assign gc_s[2] = gg_s[1] | (pp_s[1] & gg_s[0]) | (pp_s[1] & pp_s[0] & cin);
    assign gc_s[3] = gg_s[2] | (pp_s[2] & gg_s[1]) | (pp_s[2] & pp_s[1] & gg_s[0])
                   | (pp_s[2] & pp_s[1] & pp_s[0] & cin);
    assign g = gg_s[3] | (pp_s[3] & gg_s[2]) | (pp_s[3] & pp_s[2] & gg_s[1])
             | (pp_s[3] & pp_s[2] & pp_s[1] & gg_s[0]);
    assign p = &pp_s;

    // Bit carries inside each nibble from its group carry-in
    always_comb begin
        c_s = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = gc_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
        end
    end

    assign sum = p_s ^ c_s;
endmodule

module fcla16_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_cin,
    input  logic [NREQ-1:0]    req_wide,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_sum,
    output logic               resp_cout,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, RESP = 2'd3} state_t;

    state_t         state_r;
    logic [IDW-1:0] rr_ptr_r;
    logic [31:0]    a_r;
    logic [31:0]    b_r;
    logic           cin_r;
    logic           wide_r;
    logic [IDW-1:0] id_r;
    logic [15:0]    sum_lo_r;
    logic [15:0]    sum_hi_r;
    logic           c16_r;
    logic           c32_r;

    logic           grant_valid_s;
    logic [IDW-1:0] grant_idx_s;
    logic [IDW-1:0] next_ptr_s;
    logic [15:0]    add_a_s;
    logic [15:0]    add_b_s;
    logic           add_cin_s;
    logic [15:0]    add_sum_s;
    logic           add_g_s;
    logic           add_p_s;
    logic           carry_s;

    // Round-robin search: first valid index at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_r) + i) % NREQ;
            if (!grant_valid_s && req_valid[idx]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = IDW'(idx);
            end
        end
        if (grant_idx_s == IDW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + IDW'(1);
        end
    end

    // Grant is combinational and suppressed while reset is held
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_r == IDLE) && grant_valid_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Adder inputs are parked at zero outside the two compute passes
    always_comb begin
        case (state_r)
            LO:      begin add_a_s = a_r[15:0];  add_b_s = b_r[15:0];  add_cin_s = cin_r; end
            HI:      begin add_a_s = a_r[31:16]; add_b_s = b_r[31:16]; add_cin_s = c16_r; end
            default: begin add_a_s = 16'h0000;   add_b_s = 16'h0000;   add_cin_s = 1'b0;  end
        endcase
    end

    fcla16 u_add (
        .a   (add_a_s),
        .b   (add_b_s),
        .cin (add_cin_s),
        .sum (add_sum_s),
        .g   (add_g_s),
        .p   (add_p_s)
    );

    assign carry_s = add_g_s | (add_p_s & add_cin_s);
    assign busy    = (state_r != IDLE);

    // Scheduler state machine with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            a_r        <= 32'h0000_0000;
            b_r        <= 32'h0000_0000;
            cin_r      <= 1'b0;
            wide_r     <= 1'b0;
            id_r       <= '0;
            sum_lo_r   <= 16'h0000;
            sum_hi_r   <= 16'h0000;
            c16_r      <= 1'b0;
            c32_r      <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= 32'h0000_0000;
            resp_cout  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        a_r      <= req_a[32*grant_idx_s +: 32];
                        b_r      <= req_b[32*grant_idx_s +: 32];
                        cin_r    <= req_cin[grant_idx_s];
                        wide_r   <= req_wide[grant_idx_s];
                        id_r     <= grant_idx_s;
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= LO;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                LO: begin
                    sum_lo_r <= add_sum_s;
                    c16_r    <= carry_s;
                    if (wide_r) begin
                        state_r <= HI;
                    end else begin
                        sum_hi_r   <= 16'h0000;
                        resp_valid <= 1'b1;
                        resp_id    <= id_r;
                        resp_sum   <= {16'h0000, add_sum_s};
                        resp_cout  <= carry_s;
                        state_r    <= RESP;
                    end
                end
                HI: begin
                    sum_hi_r   <= add_sum_s;
                    c32_r      <= carry_s;
                    resp_valid <= 1'b1;
                    resp_id    <= id_r;
                    resp_sum   <= {add_sum_s, sum_lo_r};
                    resp_cout  <= carry_s;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fcla16_share_sched.sv
// Directed-vector bench for fcla16_share_sched: arithmetic, latency,
// round-robin order, backpressure and mid-operation reset.

module tb_fcla16_share_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]    req_cin = '0;
    logic [NREQ-1:0]    req_wide = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b1;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_sum;
    logic               resp_cout;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fcla16_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_wide   (req_wide),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One isolated request from requester id; called and returns on a negedge
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic wide, input logic [31:0] exp_sum,
                         input logic exp_cout, input int exp_lat);
        int lat;
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = '0;
        exp_rdy[id] = 1'b1;
        resp_ready = 1'b1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_cin[id] = cin;
        req_wide[id] = wide;
        #1;
        check_eq($sformatf("grant_%0d", id), 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check_eq("ready_low_busy", 32'(req_ready), 32'h0);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("latency_%0d", id), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("resp_id_%0d", id), 32'(resp_id), 32'(id));
        check_eq($sformatf("resp_sum_%0d", id), resp_sum, exp_sum);
        check_eq($sformatf("resp_cout_%0d", id), 32'(resp_cout), 32'(exp_cout));
        @(posedge clk);
        @(negedge clk);
        check_eq("resp_valid_drop", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        int exp_order[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        int last_cyc;
        int w;
        int g;

        // Reset state
        #12;
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_id", 32'(resp_id), 32'h0);
        check_eq("rst_resp_sum", resp_sum, 32'h0);
        check_eq("rst_resp_cout", 32'(resp_cout), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic and latency
        do_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 2);
        do_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 3);
        do_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 3);
        do_op(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 32'h2222_2221, 1'b0, 3);
        do_op(3, 32'hABCD_1234, 32'h1111_0F0F, 1'b1, 1'b0, 32'h0000_2144, 1'b0, 2);

        // Round-robin with all valid, requester 1 withdrawn after its first grant
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'(i);
            req_b[32*i +: 32] = 32'h0000_0100;
            req_cin[i] = 1'b0;
            req_wide[i] = 1'b0;
        end
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 9; k++) begin
            #1;
            w = 0;
            while (req_ready == '0 && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            check_eq("rr_wait_bound", 32'(w < 20), 32'h1);
            g = 0;
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
            check_eq($sformatf("rr_order_%0d", k), 32'(g), 32'(exp_order[k]));
            check_eq("rr_onehot", 32'($countones(req_ready)), 32'h1);
            if (k > 0) check_eq("rr_gap", 32'(cyc - last_cyc), 32'h3);
            last_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
            if (k == 1) req_valid[1] = 1'b0;
        end
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Backpressure: rr_ptr is 3, only requester 2 valid
        req_a[64 +: 32] = 32'h0000_0001;
        req_b[64 +: 32] = 32'h0000_0002;
        req_cin[2] = 1'b0;
        req_wide[2] = 1'b1;
        req_valid = 4'b0100;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1001;
        w = 0;
        while (!resp_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_resp_bound", 32'(resp_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_sum", resp_sum, 32'h0000_0003);
            check_eq("bp_id", 32'(resp_id), 32'h2);
            check_eq("bp_cout", 32'(resp_cout), 32'h0);
            check_eq("bp_valid", 32'(resp_valid), 32'h1);
            check_eq("bp_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_no_grant_at_hs", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("bp_regrant", 32'(req_ready), 32'h8);
        check_eq("bp_valid_low", 32'(resp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Reset during the HI pass of a wide op from requester 0 (rr_ptr is 0)
        req_wide[0] = 1'b1;
        req_a[0 +: 32] = 32'hFFFF_0000;
        req_b[0 +: 32] = 32'h0001_0000;
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_eq("hi_busy", 32'(busy), 32'h1);
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", 32'(req_ready), 32'h0);
        check_eq("arst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("arst_resp_sum", resp_sum, 32'h0);
        check_eq("arst_resp_cout", 32'(resp_cout), 32'h0);
        check_eq("arst_resp_id", 32'(resp_id), 32'h0);
        check_eq("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_rrptr", 32'(req_ready), 32'h1);
        check_eq("post_rst_no_stale", 32'(resp_valid), 32'h0);
        req_valid = '0;
        @(negedge clk);
        check_eq("post_rst_no_stale2", 32'(resp_valid), 32'h0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
